// File: rtl/ahb_traffic_gen.sv
// AHB-lite master traffic generator: programmable write, read and
// write-then-readback passes with address stride, pipelined address/data
// phases, read-data compare and ERROR response handling.
// Hresetn is asserted asynchronously; its release is expected to be
// synchronous to Hclk.
module ahb_traffic_gen #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [CNT_W-1:0]  txn_count,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] stride,
    input  logic              Hreadyout,
    input  logic [1:0]        Hresp,
    input  logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Htrans,
    output logic              Hwrite,
    output logic [ADDR_W-1:0] Haddr,
    output logic [DATA_W-1:0] Hwdata,
    output logic              Hreadyin,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [CNT_W-1:0]  mismatch_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] first_mismatch_addr
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_GAP, S_DONE} state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY    = 2'b00;
    localparam logic [1:0] HRESP_ERROR   = 2'b01;
    localparam logic [1:0] MODE_RD       = 2'b01;
    localparam logic [1:0] MODE_WR_RB    = 2'b10;

    state_t            state;
    state_t            state_nxt;

    // sequence configuration, latched at start
    logic [1:0]        mode_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] base_r;
    logic [ADDR_W-1:0] stride_r;

    // address phase (p0) and data phase (p1) of the bus pipeline
    logic [CNT_W-1:0]  idx_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              rd_pass;
    logic              vld_p1;
    logic              write_p1;
    logic [ADDR_W-1:0] addr_p1;

    logic              start_ok;
    logic              accept;
    logic              complete;
    logic              err_first;
    logic              last_addr;
    logic              rd_fail;

    // expected data of a transfer is its address fitted to the data bus
    function automatic logic [DATA_W-1:0] exp_data(input logic [ADDR_W-1:0] a);
        return DATA_W'(a);
    endfunction

    // status counters stick at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    assign start_ok  = (state == S_IDLE) && start;
    assign accept    = (state == S_ISSUE) && Hreadyout;
    assign complete  = vld_p1 && Hreadyout;
    assign err_first = vld_p1 && (Hresp == HRESP_ERROR) && !Hreadyout;
    assign last_addr = (idx_p0 == cnt_r - CNT_W'(1));
    assign rd_fail   = complete && !write_p1 && (Hresp == HRESP_OKAY) &&
                       (Hrdata != exp_data(addr_p1));

    // state register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // next-state logic; an ERROR drops straight to DRAIN so the pending
    // address is withdrawn and no further pass is started
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (txn_count == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: if (err_first || (accept && last_addr)) state_nxt = S_DRAIN;
            S_DRAIN: if (complete)
                         state_nxt = (!aborted && (mode_r == MODE_WR_RB) && !rd_pass)
                                     ? S_GAP : S_DONE;
            S_GAP:   state_nxt = S_ISSUE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // bus and handshake outputs decoded from state and pipeline registers
    always_comb begin
        Htrans   = (state == S_ISSUE) ? HTRANS_NONSEQ : HTRANS_IDLE;
        Hwrite   = (state == S_ISSUE) && !rd_pass;
        Haddr    = addr_p0;
        Hwdata   = (vld_p1 && write_p1) ? exp_data(addr_p1) : '0;
        Hreadyin = 1'b1;
        busy     = (state == S_ISSUE) || (state == S_DRAIN) || (state == S_GAP);
        done     = (state == S_DONE);
    end

    // latch sequence configuration when a start is accepted
    always_ff @(posedge Hclk) begin
        if (start_ok) begin
            mode_r   <= mode;
            cnt_r    <= txn_count;
            base_r   <= base_addr;
            stride_r <= stride;
        end
    end

    // ---- stage p0: address phase, advances when the slave accepts ----
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            addr_p0 <= '0;
            idx_p0  <= '0;
            rd_pass <= 1'b0;
        end else if (start_ok) begin
            addr_p0 <= base_addr;
            idx_p0  <= '0;
            rd_pass <= (mode == MODE_RD);
        end else if (state == S_GAP) begin
            addr_p0 <= base_r;
            idx_p0  <= '0;
            rd_pass <= 1'b1;
        end else if (accept && !last_addr) begin
            addr_p0 <= addr_p0 + stride_r;
            idx_p0  <= idx_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: data phase valid, opened on accept, closed on completion ----
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)      vld_p1 <= 1'b0;
        else if (accept)   vld_p1 <= 1'b1;
        else if (complete) vld_p1 <= 1'b0;
    end

    // data phase payload follows the accepted address
    always_ff @(posedge Hclk) begin
        if (accept) begin
            addr_p1  <= addr_p0;
            write_p1 <= !rd_pass;
        end
    end

    // status: error and read-compare accounting, cleared on start
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            aborted             <= 1'b0;
            mismatch_count      <= '0;
            err_count           <= '0;
            first_mismatch_addr <= '0;
        end else if (start_ok) begin
            aborted             <= 1'b0;
            mismatch_count      <= '0;
            err_count           <= '0;
            first_mismatch_addr <= '0;
        end else begin
            if (err_first) begin
                err_count <= sat_inc(err_count);
                aborted   <= 1'b1;
            end
            if (rd_fail) begin
                mismatch_count <= sat_inc(mismatch_count);
                if (mismatch_count == '0) first_mismatch_addr <= addr_p1;
            end
        end
    end

endmodule

// File: tb/tb_ahb_traffic_gen.sv
// Directed bench for ahb_traffic_gen with a small AHB slave responder
// (memory, wait states, forced read data, ERROR injection).
module tb_ahb_traffic_gen;

    logic        Hclk;
    logic        Hresetn;
    logic        start;
    logic [1:0]  mode;
    logic [7:0]  txn_count;
    logic [31:0] base_addr;
    logic [31:0] stride;
    logic        Hreadyout;
    logic [1:0]  Hresp;
    logic [31:0] Hrdata;
    logic [1:0]  Htrans;
    logic        Hwrite;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        Hreadyin;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [7:0]  mismatch_count;
    logic [7:0]  err_count;
    logic [31:0] first_mismatch_addr;

    ahb_traffic_gen #(.ADDR_W(32), .DATA_W(32), .CNT_W(8)) dut (
        .Hclk(Hclk), .Hresetn(Hresetn), .start(start), .mode(mode),
        .txn_count(txn_count), .base_addr(base_addr), .stride(stride),
        .Hreadyout(Hreadyout), .Hresp(Hresp), .Hrdata(Hrdata),
        .Htrans(Htrans), .Hwrite(Hwrite), .Haddr(Haddr), .Hwdata(Hwdata),
        .Hreadyin(Hreadyin), .busy(busy), .done(done), .aborted(aborted),
        .mismatch_count(mismatch_count), .err_count(err_count),
        .first_mismatch_addr(first_mismatch_addr)
    );

    initial begin
        Hclk = 1'b0;
        forever #5 Hclk = ~Hclk;
    end

    // slave configuration, written only by the stimulus block
    int          wait_cfg;
    int          err_idx;
    bit          force_en;
    logic [31:0] force_val;

    // slave state and monitor counters, written only by the slave block
    logic [31:0] mem [0:15];
    logic [31:0] acc_addr [0:511];
    bit          acc_wr [0:511];
    int          acc_cyc [0:511];
    int          acc_n, cmp_n, done_n, done_busy_n, gap_n, stab_n, wd_n, stall_n, cyc;
    logic [1:0]  err_htrans;
    bit          dp_vld, dp_wr, hold_chk;
    logic [31:0] dp_addr;
    int          dp_idx, wcnt, err_st;
    logic [1:0]  snap_trans;
    logic [31:0] snap_addr, snap_wd;
    logic        snap_wr;

    // slave: observe the current cycle, then drive the response for the next edge
    always @(negedge Hclk) begin
        cyc++;
        if (!Hresetn) begin
            dp_vld    = 1'b0;
            err_st    = 0;
            hold_chk  = 1'b0;
            Hreadyout = 1'b1;
            Hresp     = 2'b00;
            Hrdata    = 32'h0;
        end else begin
            if (done) begin
                done_n++;
                if (busy) done_busy_n++;
            end
            if (busy && Htrans == 2'b00 && !dp_vld) gap_n++;
            if (hold_chk && (Htrans !== snap_trans || Haddr !== snap_addr ||
                             Hwrite !== snap_wr || Hwdata !== snap_wd)) stab_n++;
            hold_chk = 1'b0;
            Hresp = 2'b00;
            if (dp_vld && dp_idx == err_idx && err_st == 0) begin
                Hresp     = 2'b01;
                Hreadyout = 1'b0;
                err_st    = 1;
            end else if (err_st == 1) begin
                Hresp      = 2'b01;
                Hreadyout  = 1'b1;
                err_st     = 0;
                err_htrans = Htrans;
            end else if (dp_vld && wcnt > 0) begin
                Hreadyout = 1'b0;
                wcnt--;
                stall_n++;
                hold_chk   = 1'b1;
                snap_trans = Htrans;
                snap_addr  = Haddr;
                snap_wr    = Hwrite;
                snap_wd    = Hwdata;
            end else begin
                Hreadyout = 1'b1;
            end
            if (Hreadyout) begin
                if (dp_vld) begin
                    cmp_n++;
                    if (dp_wr) begin
                        if (Hwdata !== dp_addr) wd_n++;
                        mem[dp_addr[5:2]] = Hwdata;
                    end else begin
                        Hrdata = force_en ? force_val : mem[dp_addr[5:2]];
                    end
                end
                dp_vld = (Htrans == 2'b10);
                if (dp_vld) begin
                    dp_addr = Haddr;
                    dp_wr   = Hwrite;
                    dp_idx  = acc_n;
                    wcnt    = wait_cfg;
                    acc_addr[acc_n] = Haddr;
                    acc_wr[acc_n]   = Hwrite;
                    acc_cyc[acc_n]  = cyc;
                    acc_n++;
                end
            end
        end
    end

    int total, bad;
    int b_acc, b_cmp, b_done, b_dbusy, b_gap, b_stab, b_wd, b_stall;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_acc = acc_n; b_cmp = cmp_n; b_done = done_n; b_dbusy = done_busy_n;
        b_gap = gap_n; b_stab = stab_n; b_wd = wd_n; b_stall = stall_n;
    endtask

    // pulse start for one cycle and wait (bounded) for done
    task automatic run_seq(input logic [1:0] m, input logic [7:0] n,
                           input logic [31:0] b, input logic [31:0] s);
        bit seen;
        snap();
        mode = m; txn_count = n; base_addr = b; stride = s;
        start = 1'b1;
        @(posedge Hclk); #1;
        start = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge Hclk); #1;
        end
        check("done_seen", {31'b0, seen}, 32'd1);
        @(posedge Hclk); #1;
    endtask

    initial begin
        total = 0; bad = 0;
        wait_cfg = 0; err_idx = -1; force_en = 1'b0; force_val = 32'h0;
        Hresetn = 1'b0; start = 1'b0; mode = 2'b00; txn_count = 8'd0;
        base_addr = 32'h0; stride = 32'h0;
        repeat (3) @(posedge Hclk);
        #1;
        check("rst_Htrans", {30'b0, Htrans}, 32'd0);
        check("rst_Haddr", Haddr, 32'd0);
        check("rst_Hwdata", Hwdata, 32'd0);
        check("rst_Hwrite", {31'b0, Hwrite}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_Hreadyin", {31'b0, Hreadyin}, 32'd1);
        check("rst_status", {aborted, mismatch_count, err_count}, 32'd0);
        check("rst_first_mm", first_mismatch_addr, 32'd0);
        Hresetn = 1'b1;
        repeat (2) @(posedge Hclk);
        #1;

        // write-only burst, no wait states
        run_seq(2'b00, 8'd3, 32'h8000_0054, 32'd4);
        check("B_acc", acc_n - b_acc, 32'd3);
        check("B_addr0", acc_addr[b_acc], 32'h8000_0054);
        check("B_addr1", acc_addr[b_acc+1], 32'h8000_0058);
        check("B_addr2", acc_addr[b_acc+2], 32'h8000_005C);
        check("B_wr", {29'b0, acc_wr[b_acc], acc_wr[b_acc+1], acc_wr[b_acc+2]}, 32'd7);
        check("B_b2b01", acc_cyc[b_acc+1] - acc_cyc[b_acc], 32'd1);
        check("B_b2b12", acc_cyc[b_acc+2] - acc_cyc[b_acc+1], 32'd1);
        check("B_wdata_bad", wd_n - b_wd, 32'd0);
        check("B_cmpl", cmp_n - b_cmp, 32'd3);
        check("B_done", done_n - b_done, 32'd1);
        check("B_done_busy", done_busy_n - b_dbusy, 32'd0);
        check("B_gap", gap_n - b_gap, 32'd0);
        check("B_err", {24'b0, err_count}, 32'd0);
        check("B_aborted", {31'b0, aborted}, 32'd0);

        // write-then-readback with two wait states per transfer
        wait_cfg = 2;
        run_seq(2'b10, 8'd4, 32'h0000_1000, 32'd8);
        wait_cfg = 0;
        check("C_acc", acc_n - b_acc, 32'd8);
        check("C_wr3", {31'b0, acc_wr[b_acc+3]}, 32'd1);
        check("C_rd4", {31'b0, acc_wr[b_acc+4]}, 32'd0);
        check("C_rdaddr0", acc_addr[b_acc+4], 32'h0000_1000);
        check("C_rdaddr3", acc_addr[b_acc+7], 32'h0000_1018);
        check("C_stalls", stall_n - b_stall, 32'd16);
        check("C_stable", stab_n - b_stab, 32'd0);
        check("C_gap", gap_n - b_gap, 32'd1);
        check("C_wdata_bad", wd_n - b_wd, 32'd0);
        check("C_mismatch", {24'b0, mismatch_count}, 32'd0);
        check("C_first_mm", first_mismatch_addr, 32'd0);
        check("C_done", done_n - b_done, 32'd1);

        // read-only against wrong read data
        force_en = 1'b1; force_val = 32'h1234_5678;
        run_seq(2'b01, 8'd2, 32'h8000_00AA, 32'd4);
        force_en = 1'b0;
        check("D_acc", acc_n - b_acc, 32'd2);
        check("D_rd", {30'b0, acc_wr[b_acc], acc_wr[b_acc+1]}, 32'd0);
        check("D_addr1", acc_addr[b_acc+1], 32'h8000_00AE);
        check("D_mismatch", {24'b0, mismatch_count}, 32'd2);
        check("D_first_mm", first_mismatch_addr, 32'h8000_00AA);
        check("D_err", {24'b0, err_count}, 32'd0);
        check("D_done", done_n - b_done, 32'd1);

        // ERROR on transfer index 2 of a five-transfer write pass
        err_idx = acc_n + 2;
        err_htrans = 2'b11;
        run_seq(2'b00, 8'd5, 32'h0000_0100, 32'd4);
        err_idx = -1;
        check("E_acc", acc_n - b_acc, 32'd3);
        check("E_htrans_after_err", {30'b0, err_htrans}, 32'd0);
        check("E_err", {24'b0, err_count}, 32'd1);
        check("E_aborted", {31'b0, aborted}, 32'd1);
        check("E_done", done_n - b_done, 32'd1);
        check("E_mismatch", {24'b0, mismatch_count}, 32'd0);

        // address wrap at the top of the map
        run_seq(2'b11, 8'd2, 32'hFFFF_FFFC, 32'd4);
        check("F_acc", acc_n - b_acc, 32'd2);
        check("F_addr0", acc_addr[b_acc], 32'hFFFF_FFFC);
        check("F_addr1", acc_addr[b_acc+1], 32'h0000_0000);
        check("F_wr", {30'b0, acc_wr[b_acc], acc_wr[b_acc+1]}, 32'd3);
        check("F_aborted_cleared", {31'b0, aborted}, 32'd0);
        check("F_err_cleared", {24'b0, err_count}, 32'd0);

        // zero-length sequence: done one cycle after start, nothing issued
        snap();
        mode = 2'b00; txn_count = 8'd0; base_addr = 32'h40; stride = 32'd4;
        start = 1'b1;
        @(posedge Hclk); #1;
        start = 1'b0;
        check("Z_done_now", {31'b0, done}, 32'd1);
        check("Z_busy", {31'b0, busy}, 32'd0);
        repeat (3) @(posedge Hclk);
        #1;
        check("Z_acc", acc_n - b_acc, 32'd0);
        check("Z_done_once", done_n - b_done, 32'd1);

        // asynchronous reset in the middle of a long pass
        snap();
        mode = 2'b00; txn_count = 8'd20; base_addr = 32'h2000; stride = 32'd4;
        start = 1'b1;
        @(posedge Hclk); #1;
        start = 1'b0;
        repeat (3) @(posedge Hclk);
        #1;
        check("R_busy_before", {31'b0, busy}, 32'd1);
        check("R_htrans_before", {30'b0, Htrans}, 32'd2);
        Hresetn = 1'b0;
        #1;
        check("R_Htrans", {30'b0, Htrans}, 32'd0);
        check("R_Haddr", Haddr, 32'd0);
        check("R_busy", {31'b0, busy}, 32'd0);
        check("R_Hreadyin", {31'b0, Hreadyin}, 32'd1);
        repeat (2) @(posedge Hclk);
        #1;
        Hresetn = 1'b1;
        repeat (4) @(posedge Hclk);
        #1;
        check("R_no_done", done_n - b_done, 32'd0);
        check("R_idle_after", {30'b0, Htrans}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
